// File: rtl/enemy_formation_ctrl_if.sv
// rtl/enemy_formation_ctrl_if.sv - bullet hit query req/ack channel
interface enemy_formation_ctrl_if;
  logic       hitReq;
  logic [9:0] hitX;
  logic [9:0] hitY;
  logic       hitAck;
  logic       hitValid;
  logic [2:0] hitIdx;

  modport master (output hitReq, hitX, hitY, input hitAck, hitValid, hitIdx);
  modport slave  (input hitReq, hitX, hitY, output hitAck, hitValid, hitIdx);
endinterface

// File: rtl/enemy_formation_ctrl.sv
// rtl/enemy_formation_ctrl.sv - 7-enemy formation march, bounce/drop and hit resolution
module enemy_formation_ctrl #(
  parameter int STEP_X          = 2,
  parameter int STEP_Y          = 8,
  parameter int FRAMES_PER_STEP = 4,
  parameter int X_MAX           = 440,
  parameter int Y_MAX           = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frameTick,
  input  logic                   start,
  enemy_formation_ctrl_if.slave  hit,
  output logic [9:0]             posX,
  output logic [9:0]             posY,
  output logic [6:0]             alive,
  output logic                   allDead,
  output logic                   reachedBottom
);
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [10:0] SX = 11'(STEP_X);
  localparam logic [10:0] SY = 11'(STEP_Y);
  localparam logic [10:0] XM = 11'(X_MAX);
  localparam logic [10:0] YM = 11'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_MARCH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [6:0]    alive_q, alive_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap_pend_q, cap_pend_d, cap_kill_q, cap_kill_d;
  logic [9:0]    hx_q, hx_d, hy_q, hy_d;
  logic          ack_q, ack_d, valid_q, valid_d;
  logic [2:0]    idx_q, idx_d;
  logic          dead_q, dead_d, bottom_q, bottom_d;

  logic          found;
  logic [2:0]    found_idx;
  logic [10:0]   bx, by, cx, cy;
  logic          hit_ok;

  // Scan from the top index down so the lowest alive index wins.
  always_comb begin
    found     = 1'b0;
    found_idx = 3'd0;
    bx        = {1'b0, hx_q};
    by        = {1'b0, hy_q};
    cy        = 11'd239 + {1'b0, pos_y_q};
    cx        = 11'd0;
    for (int i = 6; i >= 0; i--) begin
      cx = 11'd31 + 11'(24 * i) + {1'b0, pos_x_q};
      if (alive_q[i] && (bx + 11'd8 >= cx) && (bx <= cx + 11'd8) &&
          (by + 11'd8 >= cy) && (by <= cy + 11'd8)) begin
        found     = 1'b1;
        found_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    alive_d    = alive_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    cap_pend_d = cap_pend_q;
    cap_kill_d = cap_kill_q;
    hx_d       = hx_q;
    hy_d       = hy_q;
    ack_d      = 1'b0;
    valid_d    = valid_q;
    idx_d      = idx_q;
    dead_d     = dead_q;
    bottom_d   = bottom_q;
    hit_ok     = (state_q == S_MARCH) && !cap_kill_q && !start && found;

    if (cap_pend_q) begin
      cap_pend_d = 1'b0;
      ack_d      = 1'b1;
      valid_d    = hit_ok;
      if (hit_ok) begin
        idx_d            = found_idx;
        alive_d[found_idx] = 1'b0;
      end
    end else if (hit.hitReq && !ack_q) begin
      cap_pend_d = 1'b1;
      cap_kill_d = start;
      hx_d       = hit.hitX;
      hy_d       = hit.hitY;
    end

    // dir_q: 0 = moving right, 1 = moving left
    if (state_q == S_MARCH) begin
      if (frameTick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if ((!dir_q && ({1'b0, pos_x_q} + SX > XM)) || (dir_q && ({1'b0, pos_x_q} < SX))) begin
            dir_d = ~dir_q;
            if ({1'b0, pos_y_q} + SY >= YM) begin
              pos_y_d  = YM[9:0];
              bottom_d = 1'b1;
              state_d  = S_DONE;
            end else begin
              pos_y_d = pos_y_q + SY[9:0];
            end
          end else if (dir_q) begin
            pos_x_d = pos_x_q - SX[9:0];
          end else begin
            pos_x_d = pos_x_q + SX[9:0];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (alive_q == 7'd0) begin
        dead_d  = 1'b1;
        state_d = S_DONE;
      end
    end

    if (start) begin
      pos_x_d  = '0;
      pos_y_d  = '0;
      alive_d  = 7'h7F;
      dir_d    = 1'b0;
      cnt_d    = '0;
      dead_d   = 1'b0;
      bottom_d = 1'b0;
      state_d  = S_MARCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      alive_q    <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      cap_pend_q <= 1'b0;
      cap_kill_q <= 1'b0;
      hx_q       <= '0;
      hy_q       <= '0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      dead_q     <= 1'b0;
      bottom_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      alive_q    <= alive_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      cap_pend_q <= cap_pend_d;
      cap_kill_q <= cap_kill_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      dead_q     <= dead_d;
      bottom_q   <= bottom_d;
    end
  end

  assign hit.hitAck   = ack_q;
  assign hit.hitValid = valid_q;
  assign hit.hitIdx   = idx_q;
  assign posX          = pos_x_q;
  assign posY          = pos_y_q;
  assign alive         = alive_q;
  assign allDead       = dead_q;
  assign reachedBottom = bottom_q;
endmodule
